// File: rtl/quad_uart_wb_pkg.sv
// Shared types and field positions for the quad UART Wishbone front end.
package quad_uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CH_LSB = 3;
    localparam int REG_W  = 3;

endpackage

// File: rtl/qu_ack_timer.sv
// 8-bit saturating cycle counter for the downstream ack timeout.
module qu_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign done = (count == LIMIT);

endmodule

// File: rtl/quad_uart_wb_decoder.sv
// Wishbone slave front end: decodes one of four UART channels, steers the byte
// lane, registers the response and flags bad requests or ack timeouts.
//
// state | meaning
// IDLE  | waiting for a Wishbone request
// WAIT  | strobing the selected channel, waiting for its ack
// ACK   | one-cycle wb_ack_o
// ERR   | one-cycle wb_err_o
module quad_uart_wb_decoder
    import quad_uart_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [REG_W-1:0]    ch_adr_o,
    output logic [7:0]          ch_dat_o,
    output logic                ch_we_o,
    output logic [NUM_CH-1:0]   ch_stb_o,
    output logic [NUM_CH-1:0]   ch_cyc_o,
    input  logic [31:0]         ch_dat_i,
    input  logic [NUM_CH-1:0]   ch_ack_i,
    input  logic [NUM_CH-1:0]   ch_int_i,
    output logic                int_o
);

    state_t            state, state_nx;
    logic [CH_W-1:0]   ch_q;
    logic              req, good, accept, ch_ack, tmr_en, tmr_done;
    logic [1:0]        lane;

    assign lane   = wb_adr_i[1:0];
    assign req    = wb_cyc_i & wb_stb_i;
    assign good   = (wb_adr_i[31:5] == BASE_ADDR[31:5]) &&
                    (wb_sel_i == (4'b0001 << lane));
    assign accept = (state == ST_IDLE) && req && good;
    assign ch_ack = ch_ack_i[ch_q];

    // The count equals the current WAIT cycle number, so the last WAIT
    // cycle before the error path is cycle ACK_TIMEOUT.
    assign tmr_en = accept || (state == ST_WAIT);

    qu_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .clr   (!tmr_en),
        .en    (tmr_en),
        .done  (tmr_done)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req) state_nx = good ? ST_WAIT : ST_ERR;
            ST_WAIT: begin
                if (!wb_cyc_i)     state_nx = ST_IDLE;
                else if (ch_ack)   state_nx = ST_ACK;
                else if (tmr_done) state_nx = ST_ERR;
            end
            ST_ACK:  state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ch_q     <= '0;
            ch_adr_o <= '0;
            ch_dat_o <= 8'h00;
            ch_we_o  <= 1'b0;
            wb_dat_o <= 32'h0;
            int_o    <= 1'b0;
        end else begin
            int_o <= |ch_int_i;
            if (accept) begin
                ch_q     <= wb_adr_i[CH_LSB +: CH_W];
                ch_adr_o <= wb_adr_i[REG_W-1:0];
                ch_we_o  <= wb_we_i;
                ch_dat_o <= wb_dat_i[{lane, 3'b000} +: 8];
            end
            if (state == ST_WAIT && wb_cyc_i && ch_ack && !ch_we_o) begin
                wb_dat_o <= {4{ch_dat_i[{ch_q, 3'b000} +: 8]}};
            end
        end
    end

    assign ch_stb_o = (state == ST_WAIT) ? (NUM_CH'(1) << ch_q) : '0;
    assign ch_cyc_o = ch_stb_o;
    assign wb_ack_o = (state == ST_ACK);
    assign wb_err_o = (state == ST_ERR);

endmodule

// File: tb/tb_quad_uart_wb_decoder.sv
// Directed bench for quad_uart_wb_decoder: decode, lane steering, errors,
// timeout, abort, async reset and interrupt merge.
module tb_quad_uart_wb_decoder;

    logic        clk, rst_n;
    logic [31:0] adr, dat_w, dat_r, ch_dat;
    logic [3:0]  sel, ch_stb, ch_cyc, ch_ack, ch_int;
    logic        we, stb, cyc, ack, err, ch_we, int_o;
    logic [2:0]  ch_adr;
    logic [7:0]  ch_dat_o;

    int checks = 0;
    int failures = 0;
    int n_stb, n_ack;
    bit seen_err;

    quad_uart_wb_decoder #(.BASE_ADDR(32'h0), .ACK_TIMEOUT(255)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst_n),
        .wb_adr_i (adr),      .wb_dat_i (dat_w),    .wb_dat_o (dat_r),
        .wb_sel_i (sel),      .wb_we_i  (we),       .wb_stb_i (stb),
        .wb_cyc_i (cyc),      .wb_ack_o (ack),      .wb_err_o (err),
        .ch_adr_o (ch_adr),   .ch_dat_o (ch_dat_o), .ch_we_o  (ch_we),
        .ch_stb_o (ch_stb),   .ch_cyc_o (ch_cyc),   .ch_dat_i (ch_dat),
        .ch_ack_i (ch_ack),   .ch_int_i (ch_int),   .int_o    (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
        adr = a; sel = s; we = w; dat_w = d; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; adr = 0; dat_w = 0; sel = 0; we = 0; stb = 0; cyc = 0;
        ch_dat = 0; ch_ack = 0; ch_int = 0;
        #12;
        chk("rst_stb", 32'(ch_stb), 0);
        chk("rst_ack_err", 32'({ack, err, int_o, ch_we}), 0);
        chk("rst_dat_o", dat_r, 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: write ch1 reg4, ack two cycles after strobe
        @(negedge clk); req(32'h0C, 4'b0001, 1'b1, 32'hDEAD_BE55);
        @(negedge clk);
        chk("t1_stb", 32'(ch_stb), 32'h2);
        chk("t1_cyc", 32'(ch_cyc), 32'h2);
        chk("t1_adr", 32'(ch_adr), 32'h4);
        chk("t1_dat", 32'(ch_dat_o), 32'h55);
        chk("t1_we", 32'(ch_we), 1);
        chk("t1_no_ack_yet", 32'(ack), 0);
        @(negedge clk); ch_ack = 4'b0010;
        @(negedge clk);
        chk("t1_ack", 32'({ack, err}), 32'h2);
        chk("t1_stb_drop", 32'(ch_stb), 0);
        ch_ack = 0; drop();
        @(negedge clk);
        chk("t1_ack_single", 32'(ack), 0);

        // 2: read ch3 reg3 lane3
        ch_dat = 32'hA700_0000 | 32'h0011_2233;
        @(negedge clk); req(32'h1B, 4'b1000, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_stb", 32'(ch_stb), 32'h8);
        chk("t2_adr", 32'(ch_adr), 32'h3);
        ch_ack = 4'b1000;
        @(negedge clk);
        chk("t2_ack", 32'(ack), 1);
        chk("t2_dat", dat_r, 32'hA7A7_A7A7);
        ch_ack = 0; drop();
        @(negedge clk);
        chk("t2_ack_single", 32'(ack), 0);

        // 3: out-of-window address, then bad byte select
        @(negedge clk); req(32'h20, 4'b0001, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3a_err", 32'({ack, err}), 32'h1);
        chk("t3a_stb", 32'(ch_stb), 0);
        drop();
        @(negedge clk);
        chk("t3a_err_single", 32'(err), 0);
        req(32'h00, 4'b0011, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3b_err", 32'({ack, err}), 32'h1);
        chk("t3b_stb", 32'(ch_stb), 0);
        drop();
        @(negedge clk);
        chk("t3b_err_single", 32'(err), 0);

        // 4: timeout on ch0 with no ack
        req(32'h00, 4'b0001, 1'b0, 32'h0);
        n_stb = 0; n_ack = 0; seen_err = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
            if (err) begin
                seen_err = 1;
                chk("t4_stb_at_err", 32'(ch_stb), 0);
                break;
            end
            if (ch_stb == 4'b0001) n_stb++;
        end
        chk("t4_err_seen", 32'(seen_err), 1);
        chk("t4_wait_cycles", 32'(n_stb), 255);
        chk("t4_no_ack", 32'(n_ack), 0);
        drop();
        @(negedge clk);
        chk("t4_err_single", 32'(err), 0);

        // 5: foreign ack ignored, then abort by dropping cyc
        req(32'h00, 4'b0001, 1'b0, 32'h0);
        @(negedge clk); ch_ack = 4'b0100;
        @(negedge clk);
        chk("t5_ignored_ack", 32'({ack, err}), 0);
        chk("t5_stb_held", 32'(ch_stb), 32'h1);
        ch_ack = 0; drop();
        @(negedge clk);
        chk("t5_abort_stb", 32'(ch_stb), 0);
        chk("t5_abort_flags", 32'({ack, err}), 0);
        @(negedge clk);
        chk("t5_abort_flags2", 32'({ack, err}), 0);
        req(32'h09, 4'b0010, 1'b1, 32'h0000_3300);
        @(negedge clk);
        chk("t5_next_stb", 32'(ch_stb), 32'h2);
        chk("t5_next_adr", 32'(ch_adr), 32'h1);
        chk("t5_next_dat", 32'(ch_dat_o), 32'h33);
        ch_ack = 4'b0010;
        @(negedge clk);
        chk("t5_next_ack", 32'(ack), 1);
        chk("t5_write_keeps_dat", dat_r, 32'hA7A7_A7A7);
        ch_ack = 0; drop();
        @(negedge clk);

        // 6: async reset mid-WAIT, then interrupt merge
        ch_int = 4'b0001;
        req(32'h15, 4'b0010, 1'b1, 32'h0000_9900);
        @(negedge clk);
        chk("t6_stb", 32'(ch_stb), 32'h4);
        chk("t6_dat", 32'(ch_dat_o), 32'h99);
        chk("t6_int_pre", 32'(int_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_stb", 32'({ch_stb, ch_cyc}), 0);
        chk("t6_rst_flags", 32'({ack, err, ch_we, int_o}), 0);
        chk("t6_rst_ch", 32'({ch_adr, ch_dat_o}), 0);
        chk("t6_rst_dat_o", dat_r, 0);
        drop(); ch_int = 4'b0100;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("t6_int_before_edge", 32'(int_o), 0);
        @(negedge clk);
        chk("t6_int_after_edge", 32'(int_o), 1);
        chk("t6_idle_after_rst", 32'({ack, err, ch_stb}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
